// File: rtl/branch_decode.sv
// Branch decoder: B/BL/B.cond/CBZ into a single registered result stage.
// Optional CBNZ decode is enabled by defining CBNZ_DECODE_EN.
module branch_decode (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flag_wr,
    input  logic [3:0]  flags_in,
    input  logic        rt_zero,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        Branch,
    output logic        UncondBr,
    output logic [63:0] BrAddr26,
    output logic [63:0] CondAddr19,
    output logic        link,
    output logic [3:0]  flags_q
);

    logic       accept;
    logic [3:0] eff_flags;
    logic       is_b;
    logic       is_bl;
    logic       is_bcond;
    logic       is_cbz;
    logic       is_cbnz;
    logic       d_branch;
    logic       d_uncond;
    logic       d_link;

    // Flags are {N,Z,V,C}; odd codes invert the base test except 111x
    function automatic logic cond_eval(input logic [3:0] cond,
                                       input logic [3:0] f);
        logic n, z, v, c, base;
        n = f[3];
        z = f[2];
        v = f[1];
        c = f[0];
        case (cond[3:1])
            3'b000:  base = z;
            3'b001:  base = c;
            3'b010:  base = n;
            3'b011:  base = v;
            3'b100:  base = c & ~z;
            3'b101:  base = (n == v);
            3'b110:  base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        if (cond[0] && (cond[3:1] != 3'b111))
            return ~base;
        return base;
    endfunction

    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready && !flush;
    assign eff_flags = flag_wr ? flags_in : flags_q;

    assign is_b     = (instr[31:26] == 6'b000101);
    assign is_bl    = (instr[31:26] == 6'b100101);
    assign is_bcond = (instr[31:24] == 8'b01010100);
    assign is_cbz   = (instr[31:24] == 8'b10110100);
`ifdef CBNZ_DECODE_EN
    assign is_cbnz  = (instr[31:24] == 8'b10110101);
`else
    assign is_cbnz  = 1'b0;
`endif

    // Opcode classes are mutually exclusive; anything else is PC+4
    always_comb begin
        d_branch = 1'b0;
        d_uncond = 1'b0;
        d_link   = 1'b0;
        unique case (1'b1)
            is_b: begin
                d_branch = 1'b1;
                d_uncond = 1'b1;
            end
            is_bl: begin
                d_branch = 1'b1;
                d_uncond = 1'b1;
                d_link   = 1'b1;
            end
            is_bcond: d_branch = cond_eval(instr[3:0], eff_flags);
            is_cbz:   d_branch = rt_zero;
            is_cbnz:  d_branch = !rt_zero;
            default: ;
        endcase
    end

    // Architectural flags track every ALU flag write, handshake or not
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            flags_q <= 4'b0000;
        else if (flag_wr)
            flags_q <= flags_in;
    end

    // Single output register: load on accept, hold while stalled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            Branch     <= 1'b0;
            UncondBr   <= 1'b0;
            link       <= 1'b0;
            BrAddr26   <= 64'd0;
            CondAddr19 <= 64'd0;
        end else if (flush) begin
            out_valid  <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            Branch     <= d_branch;
            UncondBr   <= d_uncond;
            link       <= d_link;
            BrAddr26   <= {{38{instr[25]}}, instr[25:0]};
            CondAddr19 <= {{45{instr[23]}}, instr[23:5]};
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_branch_decode.sv
// Directed-vector bench for branch_decode.
// Build with CBNZ_DECODE_EN defined to exercise the CBNZ decode.
module tb_branch_decode;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic        in_valid;
    logic        in_ready;
    logic        flag_wr;
    logic [3:0]  flags_in;
    logic        rt_zero;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic        Branch;
    logic        UncondBr;
    logic [63:0] BrAddr26;
    logic [63:0] CondAddr19;
    logic        link;
    logic [3:0]  flags_q;

    int vectors;
    int errors;

    branch_decode dut (
        .clk       (clk),
        .reset     (reset),
        .instr     (instr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flag_wr   (flag_wr),
        .flags_in  (flags_in),
        .rt_zero   (rt_zero),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Branch    (Branch),
        .UncondBr  (UncondBr),
        .BrAddr26  (BrAddr26),
        .CondAddr19(CondAddr19),
        .link      (link),
        .flags_q   (flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc_b(input logic [25:0] imm);
        return {6'b000101, imm};
    endfunction

    function automatic logic [31:0] enc_bl(input logic [25:0] imm);
        return {6'b100101, imm};
    endfunction

    function automatic logic [31:0] enc_bcond(input logic [18:0] imm,
                                              input logic [3:0] cond);
        return {8'h54, imm, 1'b0, cond};
    endfunction

    function automatic logic [31:0] enc_cbz(input logic [18:0] imm);
        return {8'hB4, imm, 5'd3};
    endfunction

    task automatic test_reset();
        reset    = 1'b0;
        in_valid = 1'b1;
        instr    = enc_b(26'h3FFFFFF);
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({out_valid, Branch, UncondBr, link} !== 4'b0000) begin
            $display("FAIL reset_ctl: got %b expected 0000",
                     {out_valid, Branch, UncondBr, link});
            errors++;
        end
        vectors++;
        if (BrAddr26 !== 64'd0 || CondAddr19 !== 64'd0) begin
            $display("FAIL reset_addr: got %h/%h expected 0/0",
                     BrAddr26, CondAddr19);
            errors++;
        end
        vectors++;
        if (flags_q !== 4'b0000) begin
            $display("FAIL reset_flags: got %b expected 0000", flags_q);
            errors++;
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
            errors++;
        end
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic test_b();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        instr     = enc_b(26'h3FFFFFF);
        tick();
        vectors++;
        if ({out_valid, Branch, UncondBr, link} !== 4'b1110) begin
            $display("FAIL b_ctl: got %b expected 1110",
                     {out_valid, Branch, UncondBr, link});
            errors++;
        end
        vectors++;
        if (BrAddr26 !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            $display("FAIL b_addr: got %h expected ffffffffffffffff",
                     BrAddr26);
            errors++;
        end
        in_valid = 1'b0;
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            $display("FAIL b_drain: got %b expected 0", out_valid);
            errors++;
        end
    endtask

    task automatic test_bypass();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        flag_wr   = 1'b1;
        flags_in  = 4'b0100;
        instr     = enc_bcond(19'd8, 4'b0000);
        tick();
        vectors++;
        if ({out_valid, Branch, UncondBr} !== 3'b110) begin
            $display("FAIL bypass_eq: got %b expected 110",
                     {out_valid, Branch, UncondBr});
            errors++;
        end
        vectors++;
        if (flags_q !== 4'b0100) begin
            $display("FAIL bypass_flags: got %b expected 0100", flags_q);
            errors++;
        end
        flag_wr = 1'b0;
        flags_in = 4'b0000;
        instr   = enc_bcond(19'd8, 4'b0001);
        tick();
        vectors++;
        if (Branch !== 1'b0) begin
            $display("FAIL stored_ne: got %b expected 0", Branch);
            errors++;
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_cond_table();
        logic [3:0] fl [9];
        logic [3:0] cd [9];
        logic       ex [9];
        fl[0] = 4'b0000; cd[0] = 4'b0000; ex[0] = 1'b0;
        fl[1] = 4'b0001; cd[1] = 4'b1000; ex[1] = 1'b1;
        fl[2] = 4'b0101; cd[2] = 4'b1001; ex[2] = 1'b1;
        fl[3] = 4'b1000; cd[3] = 4'b1010; ex[3] = 1'b0;
        fl[4] = 4'b1010; cd[4] = 4'b1100; ex[4] = 1'b1;
        fl[5] = 4'b0010; cd[5] = 4'b0110; ex[5] = 1'b1;
        fl[6] = 4'b0000; cd[6] = 4'b1111; ex[6] = 1'b1;
        fl[7] = 4'b1000; cd[7] = 4'b0101; ex[7] = 1'b0;
        fl[8] = 4'b0000; cd[8] = 4'b0011; ex[8] = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        flag_wr   = 1'b1;
        for (int i = 0; i < 9; i++) begin
            flags_in = fl[i];
            instr    = enc_bcond(19'd1, cd[i]);
            tick();
            vectors++;
            if (Branch !== ex[i] || flags_q !== fl[i]) begin
                $display("FAIL cond_%0d: got br=%b fl=%b expected br=%b fl=%b",
                         i, Branch, flags_q, ex[i], fl[i]);
                errors++;
            end
        end
        flag_wr  = 1'b0;
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_cbz();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        rt_zero   = 1'b0;
        instr     = enc_cbz(19'h00010);
        tick();
        vectors++;
        if ({out_valid, Branch, UncondBr} !== 3'b100) begin
            $display("FAIL cbz_nz: got %b expected 100",
                     {out_valid, Branch, UncondBr});
            errors++;
        end
        vectors++;
        if (CondAddr19 !== 64'h10) begin
            $display("FAIL cbz_addr: got %h expected 10", CondAddr19);
            errors++;
        end
        rt_zero = 1'b1;
        instr   = enc_cbz(19'h40000);
        tick();
        vectors++;
        if (Branch !== 1'b1) begin
            $display("FAIL cbz_z: got %b expected 1", Branch);
            errors++;
        end
        vectors++;
        if (CondAddr19 !== 64'hFFFF_FFFF_FFFC_0000) begin
            $display("FAIL cbz_neg: got %h expected fffffffffffc0000",
                     CondAddr19);
            errors++;
        end
        rt_zero  = 1'b0;
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_other();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        instr     = 32'h8B00_0000;
        tick();
        vectors++;
        if ({out_valid, Branch, UncondBr, link} !== 4'b1000) begin
            $display("FAIL other_ctl: got %b expected 1000",
                     {out_valid, Branch, UncondBr, link});
            errors++;
        end
        vectors++;
        if (BrAddr26 !== 64'hFFFF_FFFF_FF00_0000 || CondAddr19 !== 64'd0) begin
            $display("FAIL other_addr: got %h/%h expected ffffffffff000000/0",
                     BrAddr26, CondAddr19);
            errors++;
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = enc_bl(26'd5);
        tick();
        instr = enc_b(26'd7);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || link !== 1'b1 ||
                Branch !== 1'b1 || BrAddr26 !== 64'd5) begin
                $display("FAIL stall_%0d: got rdy=%b v=%b lk=%b br=%b a=%h expected 0 1 1 1 5",
                         i, in_ready, out_valid, link, Branch, BrAddr26);
                errors++;
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            $display("FAIL drain_ready: got %b expected 1", in_ready);
            errors++;
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || link !== 1'b0 || BrAddr26 !== 64'd7) begin
            $display("FAIL drain_next: got v=%b lk=%b a=%h expected 1 0 7",
                     out_valid, link, BrAddr26);
            errors++;
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_flush_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        instr     = enc_b(26'd3);
        tick();
        out_ready = 1'b0;
        flush     = 1'b1;
        flag_wr   = 1'b1;
        flags_in  = 4'b1111;
        instr     = enc_bl(26'd9);
        tick();
        vectors++;
        if (out_valid !== 1'b0 || flags_q !== 4'b1111) begin
            $display("FAIL flush: got v=%b fl=%b expected 0 1111",
                     out_valid, flags_q);
            errors++;
        end
        flush   = 1'b0;
        flag_wr = 1'b0;
        instr   = enc_bl(26'd3);
        tick();
        vectors++;
        if (out_valid !== 1'b1 || link !== 1'b1) begin
            $display("FAIL post_flush: got v=%b lk=%b expected 1 1",
                     out_valid, link);
            errors++;
        end
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if ({out_valid, Branch, UncondBr, link} !== 4'b0000 ||
            BrAddr26 !== 64'd0 || CondAddr19 !== 64'd0 ||
            flags_q !== 4'b0000) begin
            $display("FAIL async_reset: got %b %h %h %b expected all zero",
                     {out_valid, Branch, UncondBr, link},
                     BrAddr26, CondAddr19, flags_q);
            errors++;
        end
        @(negedge clk);
        reset     = 1'b1;
        out_ready = 1'b1;
        instr     = enc_b(26'd4);
        tick();
        vectors++;
        if (out_valid !== 1'b1 || BrAddr26 !== 64'd4) begin
            $display("FAIL post_reset: got v=%b a=%h expected 1 4",
                     out_valid, BrAddr26);
            errors++;
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_cbnz();
        logic exp_br;
`ifdef CBNZ_DECODE_EN
        exp_br = 1'b1;
`else
        exp_br = 1'b0;
`endif
        out_ready = 1'b1;
        in_valid  = 1'b1;
        rt_zero   = 1'b0;
        instr     = {8'hB5, 19'd1, 5'd2};
        tick();
        vectors++;
        if (out_valid !== 1'b1 || Branch !== exp_br || UncondBr !== 1'b0) begin
            $display("FAIL cbnz: got v=%b br=%b ub=%b expected 1 %b 0",
                     out_valid, Branch, UncondBr, exp_br);
            errors++;
        end
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        vectors   = 0;
        errors    = 0;
        reset     = 1'b0;
        instr     = 32'd0;
        in_valid  = 1'b0;
        flag_wr   = 1'b0;
        flags_in  = 4'b0000;
        rt_zero   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_b();
        test_bypass();
        test_cond_table();
        test_cbz();
        test_other();
        test_back_to_back();
        test_flush_reset();
        test_cbnz();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/branch_decode.md
BRANCH_DECODE -- requirements
Module: branch_decode

Interface
REQ-001 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- instr  in  32  fetched instruction.
- in_valid  in  1  instr is valid.
- in_ready  out  1  block accepts instr this cycle.
- flag_wr  in  1  ALU flag-setting op completes this cycle.
- flags_in  in  4  {N,Z,V,C} from the ALU.
- rt_zero  in  1  register Rt of the presented instr reads zero.
- flush  in  1  squash held and incoming decode.
- out_valid  out  1  decode result is valid.
- out_ready  in  1  PC unit consumes the result.
- Branch  out  1  taken-branch select for the PC update.
- UncondBr  out  1  selects BrAddr26 (1) or CondAddr19 (0).
- BrAddr26  out  64  sign-extended imm26 (word offset).
- CondAddr19  out  64  sign-extended imm19 (word offset).
- link  out  1  BL decoded; X30 write requested.
- flags_q  out  4  architectural flag register {N,Z,V,C}.

Function
REQ-002 Accept instr when in_valid && in_ready; in_ready SHALL equal !out_valid || out_ready (single output register, full throughput).
REQ-003 An accepted instr SHALL appear on the outputs with out_valid=1 on the next rising edge (latency 1) and SHALL be held stable until out_valid && out_ready.
REQ-004 Decode: B is instr[31:26]=000101 and BL is 100101, both giving Branch=1, UncondBr=1; BL additionally gives link=1.
REQ-005 Decode B.cond as instr[31:24]=01010100, giving UncondBr=0 and Branch=cond(instr[3:0]).
REQ-006 Decode CBZ as instr[31:24]=10110100, giving UncondBr=0 and Branch=rt_zero.
REQ-007 Any other encoding SHALL give Branch=0, UncondBr=0, link=0, with out_valid still asserted (PC+4 path).
REQ-008 BrAddr26 SHALL equal sign-extend(instr[25:0]) and CondAddr19 SHALL equal sign-extend(instr[23:5]), both registered for every accepted instr, unshifted.
REQ-009 Condition evaluation:
- EQ Z, NE !Z.
- HS C, LO !C.
- MI N, PL !N.
- VS V, VC !V.
- HI C&!Z, LS !(C&!Z).
- GE N==V, LT N!=V.
- GT !Z&(N==V), LE !(!Z&(N==V)).
- 1110 and 1111 always true.
REQ-010 flags_q SHALL load flags_in on every edge where flag_wr=1, independent of the handshake.
REQ-011 If flag_wr=1 in the same cycle a B.cond is accepted, evaluation SHALL use flags_in (bypass), not flags_q.
REQ-012 flush=1 SHALL clear out_valid on the next edge and block acceptance that cycle; flags_q still updates per REQ-010.
REQ-013 With flush=0, out_valid=1 and out_ready=0, no new instr SHALL be accepted and all outputs SHALL stay unchanged.

Reset
REQ-014 While reset=0: out_valid=0, Branch=0, UncondBr=0, link=0, BrAddr26=0, CondAddr19=0, flags_q=4'b0000, asynchronously.
REQ-015 Reset mid-transaction SHALL discard the held decode; the first edge after reset release SHALL accept normally.

Configuration
REQ-016 With CBNZ_DECODE_EN defined, instr[31:24]=10110101 SHALL decode as CBNZ: UncondBr=0, Branch=!rt_zero.
REQ-017 Without CBNZ_DECODE_EN, that encoding SHALL decode as a non-branch per REQ-007.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- B, imm26=26'h3FFFFFF, accepted: next edge out_valid=1, Branch=1, UncondBr=1, BrAddr26=64'hFFFF_FFFF_FFFF_FFFF.
- flag_wr=1 with flags_in=4'b0100 in the same cycle as B.EQ (cond 0000) with flags_q=0: Branch=1 (bypass); flags_q=4'b0100 after the edge.
- CBZ with imm19=19'h00010, rt_zero=0: Branch=0, UncondBr=0, CondAddr19=64'h10.
- out_ready=0 for 3 cycles with a BL held: in_ready=0, link=1, and the outputs stay constant; out_ready=1 drains it the same cycle a new instr is accepted.
- flush=1 with out_valid=1: out_valid=0 next edge; reset=0 asserted asynchronously mid-cycle clears all outputs immediately.
- CBNZ with rt_zero=0: Branch=1 when CBNZ_DECODE_EN is defined, Branch=0 when it is not.
